dac_dma_sequencer: RTL and testbench

//  PL-side sequencer that re-arms the AXI DMA MM2S channel feeding the DAC stream FIFO (AD5543 path).

---
 rtl/dac_dma_pkg.sv | 45 ++++
 rtl/axil_single_writer.sv | 62 ++++++
 rtl/dac_dma_sequencer.sv | 159 +++++++++++++++
 tb/tb_dac_dma_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_dma_pkg.sv
// Shared constants and types for the DAC DMA re-arm sequencer.
package dac_dma_pkg;

  // AXI DMA register offsets relative to the DMA base address
  localparam logic [31:0] OFF_DMACR  = 32'h0000_0000;
  localparam logic [31:0] OFF_DMASR  = 32'h0000_0004;
  localparam logic [31:0] OFF_SA     = 32'h0000_0018;
  localparam logic [31:0] OFF_LENGTH = 32'h0000_0028;

  // Register bit constants
  localparam logic [31:0] DMACR_RS        = 32'h0000_0001;
  localparam logic [31:0] DMACR_IOC_IRQEN = 32'h0000_1000;
  localparam logic [31:0] DMASR_IOC_IRQ   = 32'h0000_1000;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CR,
    S_WR_SR,
    S_WR_SA,
    S_WR_LEN,
    S_WAIT_IOC,
    S_WR_ACK,
    S_HALT
  } seq_state_e;

  // States that own one AXI-Lite register write
  function automatic logic is_write_state(input seq_state_e s);
    return (s == S_WR_CR) || (s == S_WR_SR) || (s == S_WR_SA) ||
           (s == S_WR_LEN) || (s == S_WR_ACK);
  endfunction

  // Successor of each setup write once its B response is OKAY
  function automatic seq_state_e next_after_write(input seq_state_e s);
    case (s)
      S_WR_CR:  return S_WR_SR;
      S_WR_SR:  return S_WR_SA;
      S_WR_SA:  return S_WR_LEN;
      S_WR_LEN: return S_WAIT_IOC;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/axil_single_writer.sv
// One AXI4-Lite write at a time: AW and W issued together, each dropped
// after its own ready, B accepted once both have been taken.
module axil_single_writer (
  input  logic        aclk,
  input  logic        areset,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic [1:0]  resp_o,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  logic        active_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;

  // Launch a write on start, retire each channel on its own handshake
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: addr/data are reset as well so every output reads 0 out of reset.
    if (areset) begin
      active_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (start_i) begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      active_q  <= 1'b1;
      awvalid_q <= 1'b1;
      wvalid_q  <= 1'b1;
      addr_q    <= addr_i;
      data_q    <= data_i;
    end else begin
      if (awvalid_q && m_awready) awvalid_q <= 1'b0;
      if (wvalid_q && m_wready)   wvalid_q  <= 1'b0;
      if (done_o)                 active_q  <= 1'b0;
    end
  end

  // B is only accepted once both address and data have been taken
  assign m_bready  = active_q & ~awvalid_q & ~wvalid_q;
  assign done_o    = m_bready & m_bvalid;
  assign resp_o    = m_bresp;
  assign m_awaddr  = addr_q;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = data_q;
  assign m_wvalid  = wvalid_q;
  assign m_wstrb   = 4'hF;

endmodule

// File: rtl/dac_dma_sequencer.sv
// Re-arms the AXI DMA MM2S channel feeding the DAC stream FIFO: on FIFO-low
// it writes DMACR/DMASR/SA/LENGTH, waits for IOC, then clears IOC.
module dac_dma_sequencer
  import dac_dma_pkg::*;
#(
  parameter logic [31:0] DMA_BASE    = 32'h4040_0000,
  parameter logic [31:0] SRC_ADDR    = 32'h4000_0000,
  parameter int unsigned XFER_BYTES  = 400,
  parameter int unsigned IRQ_TIMEOUT = 65535
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  input  logic        fifo_low,
  input  logic        dma_irq,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        busy,
  output logic        err,
  output logic [15:0] xfer_count
);

  localparam int unsigned     TW       = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(IRQ_TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   xfer_q, xfer_d;

  logic          wr_start;
  logic [31:0]   wr_addr;
  logic [31:0]   wr_data;
  logic          wr_done;
  logic [1:0]    wr_resp;
  logic          wr_ok;

  assign wr_ok = (wr_resp == RESP_OKAY);

  // Sequencer state, IOC timeout counter, sticky error and transfer count
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      xfer_q  <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      xfer_q  <= xfer_d;
    end
  end

  // Next-state logic; the timeout counter is held at 0 outside WAIT_IOC
  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_d = state_q;
    tmo_d   = '0;
    err_d   = err_q;
    xfer_d  = xfer_q;
    unique case (state_q)
      S_IDLE: begin
        if (en && fifo_low) state_d = S_WR_CR;
      end
      S_WR_CR, S_WR_SR, S_WR_SA, S_WR_LEN, S_WR_ACK: begin
        if (wr_done) begin
          if (!wr_ok) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else if (state_q == S_WR_ACK) begin
            state_d = S_IDLE;
            xfer_d  = xfer_q + 16'd1;
          end else begin
            state_d = next_after_write(state_q);
          end
        end
      end
      S_WAIT_IOC: begin
        // An IOC arriving in the last allowed cycle still wins over expiry
        if (dma_irq) begin
          state_d = S_WR_ACK;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Launch the register write belonging to the state being entered
  always_comb begin
    wr_start = (state_d != state_q) && is_write_state(state_d);
    wr_addr  = DMA_BASE;
    wr_data  = '0;
    case (state_d)
      S_WR_CR: begin
        wr_addr = DMA_BASE + OFF_DMACR;
        wr_data = DMACR_RS | DMACR_IOC_IRQEN;
      end
      S_WR_SR, S_WR_ACK: begin
        wr_addr = DMA_BASE + OFF_DMASR;
        wr_data = DMASR_IOC_IRQ;
      end
      S_WR_SA: begin
        wr_addr = DMA_BASE + OFF_SA;
        wr_data = SRC_ADDR;
      end
      S_WR_LEN: begin
        wr_addr = DMA_BASE + OFF_LENGTH;
        wr_data = 32'(XFER_BYTES);
      end
      default: begin
        wr_addr = DMA_BASE;
      end
    endcase
  end

  axil_single_writer u_writer (
    .aclk      (aclk),
    .areset    (areset),
    .start_i   (wr_start),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .done_o    (wr_done),
    .resp_o    (wr_resp),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready)
  );

  assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
  assign err        = err_q;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_dac_dma_sequencer.sv
// Self-checking bench: an AXI-Lite slave model with programmable ready/B
// delays logs completed writes; expected writes come from the register map.
module tb_dac_dma_sequencer;

  localparam logic [31:0] BASE = 32'h4040_0000;
  localparam logic [31:0] SRC  = 32'h4000_0000;
  localparam int unsigned TMO  = 100;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        en = 1'b0;
  logic        fifo_low = 1'b0;
  logic        dma_irq = 1'b0;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
  logic        busy;
  logic        err;
  logic [15:0] xfer_count;

  dac_dma_sequencer #(
    .DMA_BASE    (BASE),
    .SRC_ADDR    (SRC),
    .XFER_BYTES  (400),
    .IRQ_TIMEOUT (TMO)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
    .en         (en),
    .fifo_low   (fifo_low),
    .dma_irq    (dma_irq),
    .m_awaddr   (m_awaddr),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wstrb    (m_wstrb),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .busy       (busy),
    .err        (err),
    .xfer_count (xfer_count)
  );

  initial forever #5 aclk = ~aclk;

  int unsigned cyc = 0;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AXI-Lite slave model ----------------
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] err_addr = '0;
  bit          aw_pend, w_pend, b_pend, aw_done, w_done;
  bit          prev_aw_wait, prev_w_wait;
  int          aw_cnt, w_cnt, b_cnt;
  int          viol = 0;
  int unsigned last_b_cyc = 0;
  logic [31:0] cur_addr, cur_data, prev_awaddr, prev_wdata;
  wr_t         obs_q[$];
  wr_t         exp_q[$];

  // Runs at every falling edge: commit last edge's handshakes, audit the
  // master's channel behaviour, then drive ready/B for the next edge.
  task automatic slave_step();
    if (areset) begin
      aw_pend = 0; w_pend = 0; b_pend = 0; aw_done = 0; w_done = 0;
      prev_aw_wait = 0; prev_w_wait = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    end else begin
      if (aw_pend) begin aw_done = 1; aw_pend = 0; end
      if (w_pend)  begin w_done = 1;  w_pend = 0;  end
      if (b_pend) begin
        b_pend = 0;
        m_bvalid = 1'b0;
        obs_q.push_back('{addr: cur_addr, data: cur_data});
        last_b_cyc = cyc;
        aw_done = 0; w_done = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end
      if (aw_done && m_awvalid) viol++;
      if (w_done && m_wvalid) viol++;
      if (m_bready && !(aw_done && w_done)) viol++;
      if (prev_aw_wait && (!m_awvalid || m_awaddr !== prev_awaddr)) viol++;
      if (prev_w_wait && (!m_wvalid || m_wdata !== prev_wdata)) viol++;
      if (m_wvalid && m_wstrb !== 4'hF) viol++;

      m_awready = 1'b0;
      if (m_awvalid && !aw_done) begin
        m_awready = (aw_cnt >= aw_dly);
        aw_cnt++;
      end
      if (m_awvalid && m_awready) begin aw_pend = 1; cur_addr = m_awaddr; end
      prev_aw_wait = m_awvalid && !m_awready;
      prev_awaddr  = m_awaddr;

      m_wready = 1'b0;
      if (m_wvalid && !w_done) begin
        m_wready = (w_cnt >= w_dly);
        w_cnt++;
      end
      if (m_wvalid && m_wready) begin w_pend = 1; cur_data = m_wdata; end
      prev_w_wait = m_wvalid && !m_wready;
      prev_wdata  = m_wdata;

      if (aw_done && w_done && !m_bvalid && !b_pend) begin
        if (b_cnt >= b_dly) begin
          m_bvalid = 1'b1;
          m_bresp  = (cur_addr == err_addr) ? 2'b10 : 2'b00;
        end else begin
          b_cnt++;
        end
      end
      if (m_bvalid && m_bready) b_pend = 1;
    end
  endtask

  initial forever begin
    @(negedge aclk);
    slave_step();
  end

  // ---------------- reference sequence + helpers ----------------
  int exp_xfer = 0;

  task automatic push_setup();
    exp_q.push_back('{addr: BASE + 32'h00, data: 32'h0000_1001});
    exp_q.push_back('{addr: BASE + 32'h04, data: 32'h0000_1000});
    exp_q.push_back('{addr: BASE + 32'h18, data: SRC});
    exp_q.push_back('{addr: BASE + 32'h28, data: 32'd400});
  endtask

  task automatic push_ack();
    exp_q.push_back('{addr: BASE + 32'h04, data: 32'h0000_1000});
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (obs_q.size() < n && k < 2000) begin
      tick();
      k++;
    end
    check(tag, 32'(obs_q.size() >= n), 32'd1);
  endtask

  task automatic compare_writes(input string tag);
    wr_t o, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({tag, "_missing"}, 32'(obs_q.size()), 32'd1);
      end else begin
        o = obs_q.pop_front();
        check({tag, "_addr"}, o.addr, e.addr);
        check({tag, "_data"}, o.data, e.data);
      end
    end
  endtask

  task automatic wait_cyc(input int unsigned target);
    int k = 0;
    while (cyc < target && k < 5000) begin
      tick();
      k++;
    end
  endtask

  // Assert the IRQ so that it is sampled in WAIT_IOC cycle 'n'
  task automatic pulse_irq_at(input int unsigned n);
    wait_cyc(last_b_cyc + n - 1);
    dma_irq = 1'b1;
    tick();
    dma_irq = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
    exp_xfer = 0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    tick();
    tick();
    check("rst_awvalid", 32'(m_awvalid), 32'd0);
    check("rst_wvalid", 32'(m_wvalid), 32'd0);
    check("rst_bready", 32'(m_bready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_awaddr", m_awaddr, 32'd0);
    areset = 1'b0;
    tick();

    // Single sequence with an always-ready OKAY slave, IOC 30 cycles in
    en = 1'b1;
    fifo_low = 1'b1;
    tick();
    check("start_awvalid", 32'(m_awvalid), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    push_setup();
    wait_writes(4, "s1_wait");
    fifo_low = 1'b0;
    compare_writes("s1");
    check("s1_busy_wait", 32'(busy), 32'd1);
    pulse_irq_at(30);
    push_ack();
    wait_writes(1, "s2_wait");
    compare_writes("s2");
    exp_xfer++;
    tick();
    check("s2_xfer", 32'(xfer_count), 32'(exp_xfer));
    check("s2_busy", 32'(busy), 32'd0);
    check("s2_err", 32'(err), 32'd0);

    // Skewed AW/W readiness and random latencies, some back-to-back
    for (int it = 0; it < 8; it++) begin
      aw_dly = (it == 0) ? 3 : (it == 1) ? 0 : int'($urandom_range(0, 4));
      w_dly  = (it == 0) ? 0 : (it == 1) ? 3 : int'($urandom_range(0, 4));
      b_dly  = int'($urandom_range(0, 3));
      en = 1'b1;
      fifo_low = 1'b1;
      push_setup();
      wait_writes(4, "loop_setup_wait");
      compare_writes("loop_setup");
      fifo_low = (it == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      pulse_irq_at($urandom_range(1, 60));
      push_ack();
      wait_writes(1, "loop_ack_wait");
      compare_writes("loop_ack");
      exp_xfer++;
      tick();
      check("loop_xfer", 32'(xfer_count), 32'(exp_xfer));
    end
    tick();
    check("loop_idle_busy", 32'(busy), 32'd0);
    check("loop_viol", 32'(viol), 32'd0);

    // SLVERR on the SA write: halt, no LENGTH write, stuck until reset
    aw_dly = 0; w_dly = 0; b_dly = 0;
    err_addr = BASE + 32'h18;
    fifo_low = 1'b1;
    exp_q.push_back('{addr: BASE + 32'h00, data: 32'h0000_1001});
    exp_q.push_back('{addr: BASE + 32'h04, data: 32'h0000_1000});
    exp_q.push_back('{addr: BASE + 32'h18, data: SRC});
    wait_writes(3, "berr_wait");
    dma_irq = 1'b1;
    repeat (40) tick();
    dma_irq = 1'b0;
    compare_writes("berr");
    check("berr_no_more_writes", 32'(obs_q.size()), 32'd0);
    check("berr_err", 32'(err), 32'd1);
    check("berr_busy", 32'(busy), 32'd0);
    check("berr_awvalid", 32'(m_awvalid), 32'd0);
    check("berr_bready", 32'(m_bready), 32'd0);
    err_addr = '0;
    fifo_low = 1'b0;
    do_reset();
    check("berr_rst_err", 32'(err), 32'd0);

    // IOC timeout: error exactly after TMO cycles of WAIT_IOC
    fifo_low = 1'b1;
    push_setup();
    wait_writes(4, "tmo_wait");
    fifo_low = 1'b0;
    compare_writes("tmo");
    wait_cyc(last_b_cyc + TMO - 1);
    check("tmo_err_before", 32'(err), 32'd0);
    check("tmo_busy_before", 32'(busy), 32'd1);
    tick();
    check("tmo_err_at", 32'(err), 32'd1);
    check("tmo_busy_at", 32'(busy), 32'd0);
    do_reset();

    // IOC in the very last allowed cycle wins over expiry
    fifo_low = 1'b1;
    push_setup();
    wait_writes(4, "tmo_irq_wait");
    fifo_low = 1'b0;
    compare_writes("tmo_irq");
    pulse_irq_at(TMO);
    check("tmo_irq_err", 32'(err), 32'd0);
    push_ack();
    wait_writes(1, "tmo_irq_ack_wait");
    compare_writes("tmo_irq_ack");
    exp_xfer++;
    tick();
    check("tmo_irq_xfer", 32'(xfer_count), 32'(exp_xfer));

    // en dropped during the SA write: sequence still completes, then idles
    aw_dly = 2; w_dly = 2; b_dly = 1;
    en = 1'b1;
    fifo_low = 1'b1;
    push_setup();
    wait_writes(2, "endrop_wait");
    en = 1'b0;
    wait_writes(4, "endrop_wait4");
    compare_writes("endrop");
    pulse_irq_at(10);
    push_ack();
    wait_writes(1, "endrop_ack_wait");
    compare_writes("endrop_ack");
    exp_xfer++;
    repeat (20) tick();
    check("endrop_no_restart", 32'(obs_q.size()), 32'd0);
    check("endrop_busy", 32'(busy), 32'd0);
    check("endrop_xfer", 32'(xfer_count), 32'(exp_xfer));

    // Asynchronous reset while AW is outstanding
    aw_dly = 50; w_dly = 0; b_dly = 0;
    en = 1'b1;
    tick();
    tick();
    check("pre_rst_awvalid", 32'(m_awvalid), 32'd1);
    #2;
    areset = 1'b1;
    #1;
    check("async_rst_awvalid", 32'(m_awvalid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_xfer", 32'(xfer_count), 32'd0);
    en = 1'b0;
    fifo_low = 1'b0;
    tick();
    areset = 1'b0;
    tick();

    check("protocol_viol", 32'(viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
